// File: rtl/servo_pwm_decoder_if.sv
// Servo PWM decoder bus.
//
// Groups the PWM line fed into the decoder and the decoded results it produces.
//   pwm_in : raw servo PWM line, asynchronous to the decoder clock
//   width  : last measured high width in ticks, saturates at 255
//   pos    : last class, 00 unknown, 01 LEFT, 10 CENTER, 11 RIGHT
//   valid  : one-cycle strobe when width/pos update
//   err    : one-cycle strobe on a malformed pulse or frame
//   lost   : level, no accepted rising edge within the timeout window
//
// master : the side that drives the line and consumes the results
// slave  : the decoder itself
interface servo_pwm_decoder_if;
  logic       pwm_in;
  logic [7:0] width;
  logic [1:0] pos;
  logic       valid;
  logic       err;
  logic       lost;

  modport master (
    output pwm_in,
    input  width,
    input  pos,
    input  valid,
    input  err,
    input  lost
  );

  modport slave (
    input  pwm_in,
    output width,
    output pos,
    output valid,
    output err,
    output lost
  );
endinterface

// File: rtl/servo_pwm_decoder.sv
// Servo PWM decoder.
//
// Samples an incoming servo PWM line on the system clock, measures the high
// width and the rise-to-rise period in ticks, and classifies each pulse as
// LEFT, CENTER or RIGHT. Malformed pulses (stuck high, frames arriving too
// early, widths outside every window) raise a one-cycle err strobe; a missing
// rising edge for TIMEOUT ticks raises the lost level.
//
// Ports:
//   clk : system clock (10 kHz nominal)
//   rst : synchronous reset, active-high
//   bus : servo_pwm_decoder_if slave modport (pwm_in in; width, pos, valid,
//         err, lost out)
//
// A falling edge on pwm_in appears as valid three clock edges later: two
// synchroniser stages plus the registered decode.
module servo_pwm_decoder #(
  parameter int unsigned LEFT_W     = 10,
  parameter int unsigned CENTER_W   = 15,
  parameter int unsigned RIGHT_W    = 20,
  parameter int unsigned TOL        = 1,
  parameter int unsigned MAX_HIGH   = 40,
  parameter int unsigned MIN_PERIOD = 150,
  parameter int unsigned TIMEOUT    = 400,
  parameter int unsigned CW         = 9
) (
  input logic               clk,
  input logic               rst,
  servo_pwm_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    StSync,
    StWaitRise,
    StHigh,
    StLow
  } state_e;

  localparam logic [CW-1:0] MaxHighC   = CW'(MAX_HIGH);
  localparam logic [CW-1:0] MinPeriodC = CW'(MIN_PERIOD);
  localparam logic [CW-1:0] TimeoutC   = CW'(TIMEOUT);

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // |w - c| <= TOL written without any subtraction that could underflow.
  function automatic logic in_window(input int unsigned w, input int unsigned c);
    return ((w + TOL) >= c) && (w <= (c + TOL));
  endfunction

  // Windows are tested lowest code first so overlapping windows resolve low.
  function automatic logic [1:0] classify(input logic [7:0] w);
    int unsigned wv;
    wv = 32'(w);
    if (in_window(wv, LEFT_W)) begin
      return 2'b01;
    end else if (in_window(wv, CENTER_W)) begin
      return 2'b10;
    end else if (in_window(wv, RIGHT_W)) begin
      return 2'b11;
    end
    return 2'b00;
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchroniser and edge detect
  // ---------------------------------------------------------------------------
  logic sync1_q;
  logic s_q;
  logic s_d_q;
  logic rise;
  logic fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
      s_d_q   <= 1'b0;
    end else begin
      sync1_q <= bus.pwm_in;
      s_q     <= sync1_q;
      s_d_q   <= s_q;
    end
  end

  assign rise = s_q & ~s_d_q;
  assign fall = ~s_q & s_d_q;

  // The synchroniser flops come out of reset at 0 regardless of the line, so s
  // is not trustworthy for the first two edges. Holding SYNC until the chain
  // has refilled keeps a pulse that was already high at reset release from
  // looking like a fresh low-then-rise.
  logic [1:0] prime_q;
  logic [1:0] prime_d;
  logic       primed;

  assign primed  = (prime_q == 2'd2);
  assign prime_d = primed ? prime_q : prime_q + 2'd1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e        state_q,    state_d;
  logic [CW-1:0] hi_cnt_q,   hi_cnt_d;
  logic [CW-1:0] per_cnt_q,  per_cnt_d;
  logic [CW-1:0] lost_cnt_q, lost_cnt_d;
  logic [7:0]    width_q,    width_d;
  logic [1:0]    pos_q,      pos_d;
  logic          valid_q,    valid_d;
  logic          err_q,      err_d;
  logic          lost_q,     lost_d;

  // Rising edge that starts a new measured frame; also restarts the lost timer.
  logic          accept;
  logic [CW-1:0] hi_inc;
  logic [31:0]   hi_ext;
  logic [7:0]    sat_width;

  assign hi_inc    = sat_inc(hi_cnt_q);
  assign hi_ext    = 32'(hi_cnt_q);
  assign sat_width = (hi_ext > 32'd255) ? 8'hff : hi_ext[7:0];

  // ---------------------------------------------------------------------------
  // Next-state / output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    hi_cnt_d  = hi_cnt_q;
    per_cnt_d = per_cnt_q;
    width_d   = width_q;
    pos_d     = pos_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    accept    = 1'b0;

    case (state_q)
      StSync: begin
        // Drop whatever pulse is in flight; only a clean low re-arms.
        if (primed && !s_q) begin
          state_d = StWaitRise;
        end
      end

      StWaitRise: begin
        if (rise) begin
          accept = 1'b1;
        end
      end

      StHigh: begin
        if (fall) begin
          width_d   = sat_width;
          pos_d     = classify(sat_width);
          valid_d   = 1'b1;
          err_d     = (pos_d == 2'b00);
          per_cnt_d = sat_inc(per_cnt_q);
          state_d   = StLow;
        end else begin
          hi_cnt_d  = hi_inc;
          per_cnt_d = sat_inc(per_cnt_q);
          if (hi_inc == MaxHighC) begin
            // Stuck high: report once and keep the last good decode.
            err_d   = 1'b1;
            state_d = StSync;
          end
        end
      end

      StLow: begin
        if (rise) begin
          if (per_cnt_q < MinPeriodC) begin
            err_d   = 1'b1;
            state_d = StSync;
          end else begin
            accept = 1'b1;
          end
        end else begin
          per_cnt_d = sat_inc(per_cnt_q);
        end
      end

      default: begin
        state_d = StSync;
      end
    endcase

    if (accept) begin
      hi_cnt_d  = CW'(1);
      per_cnt_d = CW'(1);
      state_d   = StHigh;
    end
  end

  // Loss-of-signal timer runs regardless of the FSM state.
  always_comb begin
    lost_cnt_d = lost_cnt_q;
    if (accept) begin
      lost_cnt_d = '0;
    end else if (lost_cnt_q < TimeoutC) begin
      lost_cnt_d = lost_cnt_q + CW'(1);
    end
    lost_d = valid_d ? 1'b0 : (lost_q | (lost_cnt_d == TimeoutC));
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      prime_q    <= 2'd0;
      state_q    <= StSync;
      hi_cnt_q   <= '0;
      per_cnt_q  <= '0;
      lost_cnt_q <= '0;
      width_q    <= 8'd0;
      pos_q      <= 2'b00;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      prime_q    <= prime_d;
      state_q    <= state_d;
      hi_cnt_q   <= hi_cnt_d;
      per_cnt_q  <= per_cnt_d;
      lost_cnt_q <= lost_cnt_d;
      width_q    <= width_d;
      pos_q      <= pos_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      lost_q     <= lost_d;
    end
  end

  assign bus.width = width_q;
  assign bus.pos   = pos_q;
  assign bus.valid = valid_q;
  assign bus.err   = err_q;
  assign bus.lost  = lost_q;

  // ---------------------------------------------------------------------------
  // Properties
  // ---------------------------------------------------------------------------
  valid_single_cycle: assert property (@(posedge clk) disable iff (rst) valid_q |=> !valid_q);
  err_single_cycle:   assert property (@(posedge clk) disable iff (rst) err_q |=> !err_q);
  hi_cnt_bounded:     assert property (@(posedge clk) disable iff (rst) hi_cnt_q <= MaxHighC);

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Bench for servo_pwm_decoder: table of frames plus hand-written corner cases.
// Expected events are queued when the falling edge (or offending rise) is
// driven and compared, including the cycle they should land on, whenever the
// decoder raises valid or err.
module tb_servo_pwm_decoder;

  typedef struct {
    int         w;
    int         period;
    logic [1:0] ep;
    bit         ee;
  } vec_t;

  typedef struct {
    bit         v;
    bit         e;
    logic [7:0] w;
    logic [1:0] p;
    int         c;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   found;
  int   rc;
  int   ev_idx = 0;

  logic [7:0] hold_w = 8'd0;
  logic [1:0] hold_p = 2'b00;
  exp_t       sb[$];
  exp_t       e;
  vec_t       vecs[16];

  servo_pwm_decoder_if bus_if ();

  servo_pwm_decoder #(
    .LEFT_W    (10),
    .CENTER_W  (15),
    .RIGHT_W   (20),
    .TOL       (1),
    .MAX_HIGH  (40),
    .MIN_PERIOD(150),
    .TIMEOUT   (400),
    .CW        (9)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push_exp(input bit v, input bit er, input logic [7:0] w, input logic [1:0] p,
                          input int c);
    exp_t x;
    x.v = v;
    x.e = er;
    x.w = w;
    x.p = p;
    x.c = c;
    sb.push_back(x);
    if (v) begin
      hold_w = w;
      hold_p = p;
    end
  endtask

  // One frame: high for w ticks, low for the rest of the period.
  task automatic pulse(input int w, input int period, input logic [1:0] ep, input bit ee);
    logic [7:0] wb;
    wb = (w > 255) ? 8'hff : w[7:0];
    bus_if.pwm_in = 1'b1;
    tick(w);
    bus_if.pwm_in = 1'b0;
    push_exp(1'b1, ee, wb, ep, cyc + 3);
    tick(period - w);
  endtask

  // Scoreboard side: every valid/err cycle must match the next queued event.
  always @(negedge clk) begin
    if (!rst && (bus_if.valid !== 1'b0 || bus_if.err !== 1'b0)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got valid=%b err=%b width=%0d pos=%b cycle=%0d, required no event",
                 bus_if.valid, bus_if.err, bus_if.width, bus_if.pos, cyc);
      end else begin
        e = sb.pop_front();
        if (bus_if.valid !== e.v || bus_if.err !== e.e || bus_if.width !== e.w ||
            bus_if.pos !== e.p || cyc != e.c) begin
          errors++;
          $display("FAIL event_%0d: got valid=%b err=%b width=%0d pos=%b cycle=%0d, required valid=%b err=%b width=%0d pos=%b cycle=%0d",
                   ev_idx, bus_if.valid, bus_if.err, bus_if.width, bus_if.pos, cyc,
                   e.v, e.e, e.w, e.p, e.c);
        end
      end
      ev_idx++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{15, 200, 2'b10, 1'b0};
    vecs[1]  = '{15, 200, 2'b10, 1'b0};
    vecs[2]  = '{15, 200, 2'b10, 1'b0};
    vecs[3]  = '{15, 200, 2'b10, 1'b0};
    vecs[4]  = '{15, 200, 2'b10, 1'b0};
    vecs[5]  = '{10, 200, 2'b01, 1'b0};
    vecs[6]  = '{21, 200, 2'b11, 1'b0};
    vecs[7]  = '{9,  200, 2'b01, 1'b0};
    vecs[8]  = '{17, 200, 2'b00, 1'b1};
    vecs[9]  = '{14, 200, 2'b10, 1'b0};
    vecs[10] = '{16, 200, 2'b10, 1'b0};
    vecs[11] = '{11, 200, 2'b01, 1'b0};
    vecs[12] = '{19, 200, 2'b11, 1'b0};
    vecs[13] = '{12, 200, 2'b00, 1'b1};
    vecs[14] = '{13, 200, 2'b00, 1'b1};
    vecs[15] = '{22, 200, 2'b00, 1'b1};

    bus_if.pwm_in = 1'b0;
    rst = 1'b1;
    tick(5);
    check("reset_width", bus_if.width, 0);
    check("reset_pos", bus_if.pos, 0);
    check("reset_valid", bus_if.valid, 0);
    check("reset_err", bus_if.err, 0);
    check("reset_lost", bus_if.lost, 0);
    rst = 1'b0;
    tick(3);

    for (int i = 0; i < 16; i++) begin
      pulse(vecs[i].w, vecs[i].period, vecs[i].ep, vecs[i].ee);
    end
    check("table_lost", bus_if.lost, 0);
    check("table_hold_width", bus_if.width, hold_w);
    check("table_hold_pos", bus_if.pos, hold_p);

    // Line stuck high for 60 ticks: one err at hi_cnt=40, decode unchanged.
    bus_if.pwm_in = 1'b1;
    push_exp(1'b0, 1'b1, hold_w, hold_p, cyc + 42);
    tick(60);
    bus_if.pwm_in = 1'b0;
    tick(140);
    pulse(20, 200, 2'b11, 1'b0);

    // Rise only 100 ticks after the previous one: err, pulse discarded.
    pulse(15, 100, 2'b10, 1'b0);
    bus_if.pwm_in = 1'b1;
    push_exp(1'b0, 1'b1, hold_w, hold_p, cyc + 3);
    tick(15);
    bus_if.pwm_in = 1'b0;
    tick(185);
    pulse(15, 200, 2'b10, 1'b0);

    // One frame then silence: lost rises 400 ticks after the synchronised rise.
    rc = cyc;
    bus_if.pwm_in = 1'b1;
    tick(15);
    bus_if.pwm_in = 1'b0;
    push_exp(1'b1, 1'b0, 8'd15, 2'b10, cyc + 3);
    found = -1;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (bus_if.lost === 1'b1) begin
        found = cyc;
        break;
      end
    end
    check("lost_assert_cycle", found, rc + 403);
    @(posedge clk);
    #1;
    bus_if.pwm_in = 1'b1;
    tick(10);
    bus_if.pwm_in = 1'b0;
    push_exp(1'b1, 1'b0, 8'd10, 2'b01, cyc + 3);
    tick(2);
    check("lost_held_before_valid", bus_if.lost, 1);
    tick(2);
    check("lost_cleared_by_valid", bus_if.lost, 0);
    tick(186);

    // Reset in the middle of a 20-tick pulse.
    bus_if.pwm_in = 1'b1;
    tick(10);
    check("pre_reset_width", bus_if.width, 10);
    rst = 1'b1;
    tick(1);
    check("midrst_width", bus_if.width, 0);
    check("midrst_pos", bus_if.pos, 0);
    check("midrst_lost", bus_if.lost, 0);
    check("midrst_valid_err", {bus_if.valid, bus_if.err}, 0);
    tick(1);
    rst = 1'b0;
    hold_w = 8'd0;
    hold_p = 2'b00;
    tick(8);
    bus_if.pwm_in = 1'b0;
    tick(180);
    check("post_reset_width", bus_if.width, 0);
    pulse(20, 200, 2'b11, 1'b0);

    tick(5);
    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
